// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register. It holds decoded operands and control for EX, registers pre-computed
// forwarding selects, inserts load-use bubbles and keeps a saturating count of stall cycles.
module id_ex_stage_reg #(
    parameter int DATA_W = 64,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              hold,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_rs1_data,
    input  logic [DATA_W-1:0] id_rs2_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [9:0]        id_ctrl,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_write,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_rs1_data,
    output logic [DATA_W-1:0] ex_rs2_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,
    output logic [9:0]        ex_ctrl,
    output logic [1:0]        ex_fwd_a_sel,
    output logic [1:0]        ex_fwd_b_sel,
    output logic              load_use_stall,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_WB  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    logic              r_valid;
    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_rs1_data;
    logic [DATA_W-1:0] r_rs2_data;
    logic [DATA_W-1:0] r_imm;
    logic [REG_AW-1:0] r_rs1;
    logic [REG_AW-1:0] r_rs2;
    logic [REG_AW-1:0] r_rd;
    logic [9:0]        r_ctrl;
    logic [1:0]        r_fwd_a;
    logic [1:0]        r_fwd_b;
    logic [CNT_W-1:0]  r_stall_count;

    logic       w_ex_reg_write;
    logic       w_ex_mem_read;
    logic       w_ex_rd_nz;
    logic       w_mem_rd_nz;
    logic       w_stall;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    assign w_ex_reg_write = r_ctrl[9];
    assign w_ex_mem_read  = r_ctrl[8];
    assign w_ex_rd_nz     = (r_rd != '0);
    assign w_mem_rd_nz    = (mem_rd != '0);

    // A load in EX cannot supply its value to the very next instruction; hold/flush win over the stall.
    assign w_stall = id_valid & r_valid & w_ex_mem_read & w_ex_rd_nz
                   & ((r_rd == id_rs1) | (r_rd == id_rs2))
                   & ~hold & ~flush;

    // Selects are resolved one stage early: what is in EX now sits in EX/MEM when ID reaches EX.
    always_comb begin
        w_fwd_a = SEL_RF;
        if (r_valid & w_ex_reg_write & w_ex_rd_nz & (r_rd == id_rs1))
            w_fwd_a = SEL_MEM;
        else if (mem_reg_write & w_mem_rd_nz & (mem_rd == id_rs1))
            w_fwd_a = SEL_WB;
    end

    always_comb begin
        w_fwd_b = SEL_RF;
        if (r_valid & w_ex_reg_write & w_ex_rd_nz & (r_rd == id_rs2))
            w_fwd_b = SEL_MEM;
        else if (mem_reg_write & w_mem_rd_nz & (mem_rd == id_rs2))
            w_fwd_b = SEL_WB;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid       <= 1'b0;
            r_pc          <= '0;
            r_rs1_data    <= '0;
            r_rs2_data    <= '0;
            r_imm         <= '0;
            r_rs1         <= '0;
            r_rs2         <= '0;
            r_rd          <= '0;
            r_ctrl        <= '0;
            r_fwd_a       <= SEL_RF;
            r_fwd_b       <= SEL_RF;
            r_stall_count <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_fwd_a <= SEL_RF;
            r_fwd_b <= SEL_RF;
        end else if (hold) begin
            r_valid <= r_valid;
        end else if (w_stall) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_fwd_a <= SEL_RF;
            r_fwd_b <= SEL_RF;
            if (r_stall_count != '1)
                r_stall_count <= r_stall_count + 1'b1;
        end else begin
            r_valid    <= id_valid;
            r_pc       <= id_pc;
            r_rs1_data <= id_rs1_data;
            r_rs2_data <= id_rs2_data;
            r_imm      <= id_imm;
            r_rs1      <= id_rs1;
            r_rs2      <= id_rs2;
            r_rd       <= id_rd;
            r_ctrl     <= id_valid ? id_ctrl : 10'd0;
            r_fwd_a    <= w_fwd_a;
            r_fwd_b    <= w_fwd_b;
        end
    end

    assign ex_valid       = r_valid;
    assign ex_pc          = r_pc;
    assign ex_rs1_data    = r_rs1_data;
    assign ex_rs2_data    = r_rs2_data;
    assign ex_imm         = r_imm;
    assign ex_rs1         = r_rs1;
    assign ex_rs2         = r_rs2;
    assign ex_rd          = r_rd;
    assign ex_ctrl        = r_ctrl;
    assign ex_fwd_a_sel   = r_fwd_a;
    assign ex_fwd_b_sel   = r_fwd_b;
    assign load_use_stall = w_stall;
    assign stall_count    = r_stall_count;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: forwarding priority, load-use bubbles, x0 handling,
// flush/hold precedence and counter saturation on a narrow-counter build.
module tb_id_ex_stage_reg;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        hold;
    logic        id_valid;
    logic [63:0] id_pc;
    logic [63:0] id_rs1_data;
    logic [63:0] id_rs2_data;
    logic [63:0] id_imm;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic [9:0]  id_ctrl;
    logic [4:0]  mem_rd;
    logic        mem_reg_write;

    logic        ex_valid;
    logic [63:0] ex_pc;
    logic [63:0] ex_rs1_data;
    logic [63:0] ex_rs2_data;
    logic [63:0] ex_imm;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [4:0]  ex_rd;
    logic [9:0]  ex_ctrl;
    logic [1:0]  ex_fwd_a_sel;
    logic [1:0]  ex_fwd_b_sel;
    logic        load_use_stall;
    logic [31:0] stall_count;

    logic        s_ex_valid;
    logic [63:0] s_ex_pc;
    logic [63:0] s_ex_rs1_data;
    logic [63:0] s_ex_rs2_data;
    logic [63:0] s_ex_imm;
    logic [4:0]  s_ex_rs1;
    logic [4:0]  s_ex_rs2;
    logic [4:0]  s_ex_rd;
    logic [9:0]  s_ex_ctrl;
    logic [1:0]  s_ex_fwd_a_sel;
    logic [1:0]  s_ex_fwd_b_sel;
    logic        s_load_use_stall;
    logic [3:0]  s_stall_count;

    int errors;
    int checks;
    int exp_cnt;

    localparam logic [9:0] C_ALU  = 10'h200;
    localparam logic [9:0] C_LOAD = 10'h300;

    id_ex_stage_reg dut (
        .clk(clk), .reset(reset), .flush(flush), .hold(hold),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_rd(id_rd), .id_ctrl(id_ctrl),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
        .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
        .ex_fwd_a_sel(ex_fwd_a_sel), .ex_fwd_b_sel(ex_fwd_b_sel),
        .load_use_stall(load_use_stall), .stall_count(stall_count)
    );

    id_ex_stage_reg #(.CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .flush(flush), .hold(hold),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_rd(id_rd), .id_ctrl(id_ctrl),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .ex_valid(s_ex_valid), .ex_pc(s_ex_pc), .ex_rs1_data(s_ex_rs1_data),
        .ex_rs2_data(s_ex_rs2_data), .ex_imm(s_ex_imm), .ex_rs1(s_ex_rs1),
        .ex_rs2(s_ex_rs2), .ex_rd(s_ex_rd), .ex_ctrl(s_ex_ctrl),
        .ex_fwd_a_sel(s_ex_fwd_a_sel), .ex_fwd_b_sel(s_ex_fwd_b_sel),
        .load_use_stall(s_load_use_stall), .stall_count(s_stall_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [63:0] pc, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [4:0] rd, input logic [9:0] ctrl);
        id_valid    = v;
        id_pc       = pc;
        id_rs1_data = pc + 64'h1000;
        id_rs2_data = pc + 64'h2000;
        id_imm      = pc + 64'h3000;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rd       = rd;
        id_ctrl     = ctrl;
        #1;
    endtask

    task automatic drive_mem(input logic [4:0] rd, input logic rw);
        mem_rd        = rd;
        mem_reg_write = rw;
        #1;
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        exp_cnt = 0;
        reset   = 1'b1;
        flush   = 1'b0;
        hold    = 1'b0;
        drive_mem(5'd0, 1'b0);
        drive_id(1'b1, 64'h40, 5'd1, 5'd2, 5'd3, C_ALU);

        // T1 reset with a valid ID instruction present
        step();
        step();
        check("rst_valid", {63'd0, ex_valid}, 64'd0);
        check("rst_ctrl", {54'd0, ex_ctrl}, 64'd0);
        check("rst_fwd_a", {62'd0, ex_fwd_a_sel}, 64'd0);
        check("rst_fwd_b", {62'd0, ex_fwd_b_sel}, 64'd0);
        check("rst_cnt", {32'd0, stall_count}, 64'd0);
        check("rst_pc", ex_pc, 64'd0);
        reset = 1'b0;

        // T2 EX/MEM forwarding beats MEM/WB
        drive_id(1'b1, 64'h100, 5'd1, 5'd2, 5'd5, C_ALU);
        step();
        check("t2_ld_valid", {63'd0, ex_valid}, 64'd1);
        check("t2_ld_rd", {59'd0, ex_rd}, 64'd5);
        check("t2_ld_pc", ex_pc, 64'h100);
        check("t2_ld_imm", ex_imm, 64'h3100);
        drive_id(1'b1, 64'h104, 5'd5, 5'd5, 5'd6, C_ALU);
        drive_mem(5'd5, 1'b1);
        check("t2_no_stall", {63'd0, load_use_stall}, 64'd0);
        step();
        check("t2_fwd_a", {62'd0, ex_fwd_a_sel}, 64'd2);
        check("t2_fwd_b", {62'd0, ex_fwd_b_sel}, 64'd2);
        check("t2_pc", ex_pc, 64'h104);

        // MEM/WB-only match on rs1, no match on rs2
        drive_id(1'b1, 64'h108, 5'd3, 5'd9, 5'd4, C_ALU);
        drive_mem(5'd3, 1'b1);
        step();
        check("wb_fwd_a", {62'd0, ex_fwd_a_sel}, 64'd1);
        check("wb_fwd_b", {62'd0, ex_fwd_b_sel}, 64'd0);

        // T3 load-use: one bubble then the re-presented instruction forwards from MEM/WB
        drive_mem(5'd0, 1'b0);
        drive_id(1'b1, 64'h1F0, 5'd1, 5'd2, 5'd7, C_LOAD);
        step();
        drive_id(1'b1, 64'h200, 5'd1, 5'd7, 5'd8, C_ALU);
        check("t3_stall", {63'd0, load_use_stall}, 64'd1);
        step();
        exp_cnt++;
        check("t3_bub_valid", {63'd0, ex_valid}, 64'd0);
        check("t3_bub_ctrl", {54'd0, ex_ctrl}, 64'd0);
        check("t3_cnt", {32'd0, stall_count}, 64'(exp_cnt));
        check("t3_stall_off", {63'd0, load_use_stall}, 64'd0);
        drive_mem(5'd7, 1'b1);
        step();
        check("t3_re_valid", {63'd0, ex_valid}, 64'd1);
        check("t3_re_fwd_b", {62'd0, ex_fwd_b_sel}, 64'd1);
        check("t3_re_fwd_a", {62'd0, ex_fwd_a_sel}, 64'd0);
        check("t3_re_rs2d", ex_rs2_data, 64'h2200);

        // T4 x0 destination never forwards or stalls
        drive_mem(5'd0, 1'b1);
        drive_id(1'b1, 64'h300, 5'd1, 5'd2, 5'd0, C_LOAD);
        step();
        drive_id(1'b1, 64'h304, 5'd0, 5'd0, 5'd11, C_ALU);
        check("t4_no_stall", {63'd0, load_use_stall}, 64'd0);
        step();
        check("t4_fwd_a", {62'd0, ex_fwd_a_sel}, 64'd0);
        check("t4_fwd_b", {62'd0, ex_fwd_b_sel}, 64'd0);
        check("t4_valid", {63'd0, ex_valid}, 64'd1);

        // Invalid ID instruction loads with control forced to zero
        drive_mem(5'd0, 1'b0);
        drive_id(1'b0, 64'h308, 5'd1, 5'd2, 5'd3, 10'h3FF);
        step();
        check("inv_valid", {63'd0, ex_valid}, 64'd0);
        check("inv_ctrl", {54'd0, ex_ctrl}, 64'd0);

        // T5 flush+hold together bubble; hold masks the stall and freezes the counter
        drive_id(1'b1, 64'h400, 5'd1, 5'd2, 5'd7, C_LOAD);
        step();
        drive_id(1'b1, 64'h404, 5'd7, 5'd2, 5'd8, C_ALU);
        check("t5_stall", {63'd0, load_use_stall}, 64'd1);
        hold = 1'b1;
        #1;
        check("t5_hold_mask", {63'd0, load_use_stall}, 64'd0);
        flush = 1'b1;
        step();
        check("t5_fh_valid", {63'd0, ex_valid}, 64'd0);
        check("t5_fh_ctrl", {54'd0, ex_ctrl}, 64'd0);
        check("t5_fh_cnt", {32'd0, stall_count}, 64'(exp_cnt));
        flush = 1'b0;
        hold  = 1'b0;
        drive_id(1'b1, 64'h500, 5'd4, 5'd5, 5'd10, 10'h2AB);
        drive_mem(5'd4, 1'b1);
        step();
        hold = 1'b1;
        drive_id(1'b1, 64'h600, 5'd10, 5'd10, 5'd12, C_LOAD);
        drive_mem(5'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t5_h_valid", {63'd0, ex_valid}, 64'd1);
            check("t5_h_pc", ex_pc, 64'h500);
            check("t5_h_ctrl", {54'd0, ex_ctrl}, 64'h2AB);
            check("t5_h_rd", {59'd0, ex_rd}, 64'd10);
            check("t5_h_fwd_a", {62'd0, ex_fwd_a_sel}, 64'd1);
            check("t5_h_cnt", {32'd0, stall_count}, 64'(exp_cnt));
        end
        hold = 1'b0;

        // T6 saturation: narrow counter stops at 4'hF, wide one keeps counting
        for (int i = 0; i < 16; i++) begin
            drive_id(1'b1, 64'h700, 5'd1, 5'd2, 5'd7, C_LOAD);
            step();
            drive_id(1'b1, 64'h704, 5'd7, 5'd3, 5'd9, C_ALU);
            step();
            exp_cnt++;
        end
        check("t6_wide_cnt", {32'd0, stall_count}, 64'(exp_cnt));
        check("t6_sat_cnt", {60'd0, s_stall_count}, 64'hF);
        check("t6_sat_bub", {63'd0, s_ex_valid}, 64'd0);

        // Reset mid-stall cancels the bubble count and clears state
        drive_id(1'b1, 64'h800, 5'd1, 5'd2, 5'd7, C_LOAD);
        step();
        drive_id(1'b1, 64'h804, 5'd7, 5'd3, 5'd9, C_ALU);
        check("rs_stall", {63'd0, load_use_stall}, 64'd1);
        reset = 1'b1;
        step();
        check("rs_cnt", {32'd0, stall_count}, 64'd0);
        check("rs_sat_cnt", {60'd0, s_stall_count}, 64'd0);
        check("rs_valid", {63'd0, ex_valid}, 64'd0);
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
